// File: rtl/mem_burst_resp.sv
// mem_burst_resp
// Memory-side responder for the cache refill protocol. Each request sampled
// in IDLE returns one 32-bit word from an internal word-addressed SRAM with a
// one-cycle ack pulse. The load port writes the SRAM at any time.
//
// Optional feature macro: MEM_RESP_WAIT_EN
//   defined   : a 4-bit wait counter inserts WAIT_CYCLES wait states per word
//   undefined : no wait counter; WAIT exits to ACK on its first cycle
//
// Ports
//   i_ck        clock, rising edge
//   i_rb        asynchronous active-low reset
//   i_mem_req   request, held high by the cache for the whole burst
//   i_mem_addr  word address, captured in IDLE only
//   o_mem_ack   one-cycle ack, o_mem_data valid in the same cycle
//   o_mem_data  returned word, registered, held between acks
//   i_ld_we     load-port write enable
//   i_ld_addr   load-port word address
//   i_ld_data   load-port write data
//   o_busy      high whenever the responder is not IDLE
module mem_burst_resp #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned WAIT_CYCLES    = 2
) (
  input  logic                      i_ck,
  input  logic                      i_rb,
  input  logic                      i_mem_req,
  input  logic [29:0]               i_mem_addr,
  output logic                      o_mem_ack,
  output logic [31:0]               o_mem_data,
  input  logic                      i_ld_we,
  input  logic [MEM_ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [31:0]               i_ld_data,
  output logic                      o_busy
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned HI_W  = 30 - MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  // Only the out-of-range part of the captured address is kept: the SRAM
  // read is launched from i_mem_addr at the capture edge itself.
  logic [HI_W-1:0]   addr_hi_q, addr_hi_d;
  logic              ack_q, ack_d;
  logic [31:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              wait_done;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rd_data_q;
  logic              rd_en;

`ifdef MEM_RESP_WAIT_EN
  logic [3:0]        wait_cnt_q, wait_cnt_d;

  assign wait_done = (wait_cnt_q == '0);
`else
  assign wait_done = 1'b1;
`endif

  assign rd_en = (state_q == IDLE) && i_mem_req;

  // Read-first SRAM: a load write to the address read on the same edge
  // leaves the old word in rd_data_q.
  always_ff @(posedge i_ck) begin
    if (i_ld_we) begin
      mem_q[i_ld_addr] <= i_ld_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[i_mem_addr[MEM_ADDR_WIDTH-1:0]];
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    ack_d     = 1'b0;
    data_d    = data_q;
`ifdef MEM_RESP_WAIT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_mem_req) begin
          addr_hi_d = i_mem_addr[29:MEM_ADDR_WIDTH];
`ifdef MEM_RESP_WAIT_EN
          wait_cnt_d = 4'(WAIT_CYCLES);
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!i_mem_req) begin
          state_d = IDLE;
        end else if (wait_done) begin
          ack_d   = 1'b1;
          data_d  = (addr_hi_q != '0) ? '0 : rd_data_q;
          state_d = ACK;
        end else begin
`ifdef MEM_RESP_WAIT_EN
          wait_cnt_d = wait_cnt_q - 4'd1;
`endif
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_ck or negedge i_rb) begin
    if (!i_rb) begin
      state_q   <= IDLE;
      addr_hi_q <= '0;
      ack_q     <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
`ifdef MEM_RESP_WAIT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
`ifdef MEM_RESP_WAIT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign o_mem_ack  = ack_q;
  assign o_mem_data = data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_mem_burst_resp.sv
// Self-checking bench for mem_burst_resp: a cache-like driver pushes the
// expected word and ack cycle for every request into a scoreboard; a monitor
// pops and compares on each ack.
module tb_mem_burst_resp;

  localparam int unsigned AW      = 10;
  localparam int unsigned TB_WAIT = 2;
`ifdef MEM_RESP_WAIT_EN
  localparam int unsigned W = TB_WAIT;
`else
  localparam int unsigned W = 0;
`endif

  logic            i_ck;
  logic            i_rb;
  logic            i_mem_req;
  logic [29:0]     i_mem_addr;
  logic            o_mem_ack;
  logic [31:0]     o_mem_data;
  logic            i_ld_we;
  logic [AW-1:0]   i_ld_addr;
  logic [31:0]     i_ld_data;
  logic            o_busy;

  mem_burst_resp #(
    .MEM_ADDR_WIDTH (AW),
    .WAIT_CYCLES    (TB_WAIT)
  ) dut (
    .i_ck       (i_ck),
    .i_rb       (i_rb),
    .i_mem_req  (i_mem_req),
    .i_mem_addr (i_mem_addr),
    .o_mem_ack  (o_mem_ack),
    .o_mem_data (o_mem_data),
    .i_ld_we    (i_ld_we),
    .i_ld_addr  (i_ld_addr),
    .i_ld_data  (i_ld_data),
    .o_busy     (o_busy)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t          sb[$];
  int unsigned   cyc;
  int unsigned   n_checks;
  int unsigned   n_errors;
  logic [31:0]   model_mem [1 << AW];
  logic [31:0]   exp_hold;
  int unsigned   prev_ack_cyc;
  bit            have_prev;

  initial begin
    i_ck = 1'b0;
    forever #5 i_ck = ~i_ck;
  end

  initial cyc = 0;
  always @(posedge i_ck) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    logic [29:0] hi;
    hi = a >> AW;
    return (hi != '0) ? 32'h0 : model_mem[a[AW-1:0]];
  endfunction

  // Ack monitor
  always @(negedge i_ck) begin
    if (i_rb && o_mem_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_data", o_mem_data, e.data);
        check("ack_cycle", cyc, e.cyc);
      end
      if (have_prev) check("ack_spacing", 32'(cyc - prev_ack_cyc >= 3 + W), 32'd1);
      prev_ack_cyc = cyc;
      have_prev    = 1'b1;
    end
  end

  task automatic load(input logic [29:0] a, input logic [31:0] d);
    @(negedge i_ck);
    i_ld_we   = 1'b1;
    i_ld_addr = a[AW-1:0];
    i_ld_data = d;
    model_mem[a[AW-1:0]] = d;
    @(negedge i_ck);
    i_ld_we = 1'b0;
  endtask

  // Cache-side burst: one word per request, address incremented after each ack.
  // With ld_hit the first capture coincides with a load write to that word.
  task automatic burst(input logic [29:0] a0, input int unsigned n,
                       input bit ld_hit, input logic [31:0] ld_val);
    int unsigned t;
    logic [29:0] a;
    exp_t        e;
    @(negedge i_ck);
    for (int unsigned k = 0; k < n; k++) begin
      t = cyc;
      a = a0 + 30'(k);
      i_mem_req  = 1'b1;
      i_mem_addr = a;
      e.data = exp_word(a);
      e.cyc  = t + 2 + W;
      sb.push_back(e);
      exp_hold = e.data;
      if (ld_hit && k == 0) begin
        i_ld_we   = 1'b1;
        i_ld_addr = a[AW-1:0];
        i_ld_data = ld_val;
        model_mem[a[AW-1:0]] = ld_val;
      end
      @(negedge i_ck);
      i_ld_we    = 1'b0;
      i_mem_addr = ~a;
      check("busy_wait", {31'd0, o_busy}, 32'd1);
      while (cyc < t + 2 + W) @(negedge i_ck);
      if (k + 1 == n) i_mem_req = 1'b0;
      else            @(negedge i_ck);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge i_ck);
    check("sb_empty", sb.size(), 32'd0);
    check("data_hold", o_mem_data, exp_hold);
    check("idle_busy", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    have_prev  = 1'b0;
    exp_hold   = 32'h0;
    i_rb       = 1'b0;
    i_mem_req  = 1'b0;
    i_mem_addr = '0;
    i_ld_we    = 1'b0;
    i_ld_addr  = '0;
    i_ld_data  = '0;
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = 32'h0;

    repeat (3) @(posedge i_ck);
    @(negedge i_ck);
    check("rst_ack", {31'd0, o_mem_ack}, 32'd0);
    check("rst_data", o_mem_data, 32'h0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    i_rb = 1'b1;

    for (int i = 0; i < 8; i++) load(30'h100 + 30'(i), 32'hA000_0000 + 32'(i));

    // 8-word refill from 0x100
    burst(30'h100, 8, 1'b0, 32'h0);
    settle();

    // single word
    burst(30'h105, 1, 1'b0, 32'h0);
    settle();

    // abort during WAIT: no ack, data unchanged
    @(negedge i_ck);
    i_mem_req  = 1'b1;
    i_mem_addr = 30'h102;
    @(posedge i_ck);
    #1;
    i_mem_req = 1'b0;
    check("abort_busy", {31'd0, o_busy}, 32'd1);
    settle();

    // out-of-range address
    burst(30'h0000_0400, 1, 1'b0, 32'h0);
    settle();

    // reset asserted in WAIT mid-burst
    burst(30'h103, 1, 1'b0, 32'h0);
    settle();
    @(negedge i_ck);
    i_mem_req  = 1'b1;
    i_mem_addr = 30'h100;
    @(posedge i_ck);
    #2;
    i_rb = 1'b0;
    #1;
    check("mid_rst_ack", {31'd0, o_mem_ack}, 32'd0);
    check("mid_rst_data", o_mem_data, 32'h0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    i_mem_req = 1'b0;
    exp_hold  = 32'h0;
    @(negedge i_ck);
    i_rb = 1'b1;
    settle();
    burst(30'h100, 1, 1'b0, 32'h0);
    settle();

    // read-first collision, then the new word
    burst(30'h101, 1, 1'b1, 32'h1234_5678);
    settle();
    burst(30'h101, 1, 1'b0, 32'h0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
